sev_seg_scan_ctrl: RTL and testbench

//   Time-multiplex scan controller for NUM_DIGITS common-anode 7-seg digits.

---
 rtl/sev_seg_scan_ctrl.sv | 116 +++++++++++
 tb/tb_sev_seg_scan_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/sev_seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-seg digits feeding one shared registered decoder.
// Optional leading-zero blanking is enabled by defining SEV_SEG_LZB_EN.
module sev_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  output logic [3:0]              digit_num,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [0:0]              state, nxt_state;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [IW-1:0]           idx, nxt_idx;
  logic [4*NUM_DIGITS-1:0] disp_reg, nxt_disp, shadow;
  logic                    nxt_pending, nxt_frame;
  logic [NUM_DIGITS-1:0]   nxt_an;
  logic                    slot_end, wrap, lit;

  assign slot_end = (state == SHOW) && (cnt == SLOT_LAST);
  assign wrap     = slot_end && (idx == IDX_LAST);

  always_comb begin
    nxt_state   = state;
    nxt_cnt     = cnt;
    nxt_idx     = idx;
    nxt_disp    = disp_reg;
    nxt_pending = pending;
    nxt_frame   = 1'b0;
    if (!en) begin
      // Disabled: park at digit 0 and let any new value take effect at once.
      nxt_state   = BLANK;
      nxt_cnt     = '0;
      nxt_idx     = '0;
      if (load)         nxt_disp = din;
      else if (pending) nxt_disp = shadow;
      nxt_pending = 1'b0;
    end else begin
      if (state == BLANK && cnt == BLANK_LAST) begin
        nxt_state = SHOW;
        nxt_cnt   = cnt + CW'(1);
      end else if (slot_end) begin
        nxt_state = BLANK;
        nxt_cnt   = '0;
        nxt_idx   = wrap ? '0 : idx + IW'(1);
      end else begin
        nxt_cnt   = cnt + CW'(1);
      end
      // Frame boundary is the only point the displayed word may change.
      if (wrap) begin
        nxt_frame   = 1'b1;
        if (load)         nxt_disp = din;
        else if (pending) nxt_disp = shadow;
        nxt_pending = 1'b0;
      end else if (load) begin
        nxt_pending = 1'b1;
      end
    end
  end

`ifdef SEV_SEG_LZB_EN
  logic [NUM_DIGITS-1:0] upper_nz;
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lzb
    assign upper_nz[k] = |nxt_disp[4*NUM_DIGITS-1:4*k];
  end
  assign lit = (nxt_idx == '0) || upper_nz[nxt_idx];
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    nxt_an = '1;
    if (nxt_state == SHOW && lit) nxt_an[nxt_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      disp_reg   <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      digit_num  <= 4'd0;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      idx        <= nxt_idx;
      disp_reg   <= nxt_disp;
      pending    <= nxt_pending;
      an_n       <= nxt_an;
      frame_done <= nxt_frame;
      if (load) shadow <= din;
      // Decoder input moves only when entering BLANK, giving it time before the anode lights.
      if (!en || slot_end) digit_num <= nxt_disp[4*int'(nxt_idx) +: 4];
    end
  end

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Randomized bench for sev_seg_scan_ctrl against a position-in-frame reference model.
// Honours SEV_SEG_LZB_EN the same way as the design.
module tb_sev_seg_scan_ctrl;
  localparam int ND = 4, DIV = 8, BLK = 2, FRAME = ND * DIV;

  logic clk = 1'b0, rst, en, load;
  logic [4*ND-1:0] din;
  logic [3:0] digit_num;
  logic [ND-1:0] an_n;
  logic frame_done, pending;

  int checks = 0, errors = 0;

  // Reference state: pos = enabled cycles since scanning (re)started
  int pos;
  logic [4*ND-1:0] m_disp, m_shadow;
  logic m_pend;

  sev_seg_scan_ctrl #(.NUM_DIGITS(ND), .CLK_DIV(DIV), .BLANK_CYCLES(BLK)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
    .digit_num(digit_num), .an_n(an_n), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit boundary;
    if (rst) begin
      pos = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    end else begin
      boundary = !en || ((pos + 1) % FRAME == 0);
      if (boundary) begin
        if (load)        m_disp = din;
        else if (m_pend) m_disp = m_shadow;
        m_pend = 1'b0;
      end else if (load) begin
        m_pend = 1'b1;
      end
      if (load) m_shadow = din;
      pos = en ? pos + 1 : 0;
    end
  endtask

  task automatic check_outputs();
    int slot, phase;
    bit lit;
    logic [ND-1:0] e_an;
    slot  = (pos / DIV) % ND;
    phase = pos % DIV;
`ifdef SEV_SEG_LZB_EN
    lit = (slot == 0) || ((m_disp >> (4 * slot)) != 0);
`else
    lit = 1'b1;
`endif
    e_an = '1;
    if (phase >= BLK && lit) e_an[slot] = 1'b0;
    chk("an_n", 32'(an_n), 32'(e_an));
    chk("digit_num", 32'(digit_num), 32'((m_disp >> (4 * slot)) & 16'hF));
    chk("frame_done", 32'(frame_done), 32'(pos != 0 && pos % FRAME == 0));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  function automatic logic [4*ND-1:0] rand_word();
    logic [4*ND-1:0] w;
    w = 16'($urandom);
    for (int k = 0; k < ND; k++)
      if ($urandom_range(0, 2) == 0) w[4*k +: 4] = 4'h0;
    return w;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; din = '0;
    pos = 0; m_disp = '0; m_shadow = '0; m_pend = 1'b0;
    repeat (3) step();
    chk("reset_an", 32'(an_n), 32'(4'b1111));
    chk("reset_digit", 32'(digit_num), 32'd0);

    // Directed: load 1234 mid-frame with scanning on, run past the frame it takes effect in.
    rst = 1'b0; en = 1'b1;
    step();
    load = 1'b1; din = 16'h1234;
    step();
    load = 1'b0;
    repeat (2 * FRAME) step();
    // Mid-frame load of ABCD at cycle 10
    while (pos % FRAME != 9) step();
    load = 1'b1; din = 16'hABCD;
    step();
    load = 1'b0;
    chk("midframe_pending", 32'(pending), 32'd1);
    repeat (2 * FRAME) step();
    // Load landing on the wrap edge
    while ((pos + 1) % FRAME != 0) step();
    load = 1'b1; din = 16'h0050;
    step();
    load = 1'b0;
    chk("wrap_load_pending", 32'(pending), 32'd0);
    repeat (FRAME) step();
    // Reset during SHOW of digit 2
    while (pos % FRAME != 2 * DIV + 4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midshow_rst_an", 32'(an_n), 32'(4'b1111));
    repeat (FRAME + 5) step();

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 149) == 0) en = ~en;
      else if (!en && $urandom_range(0, 9) == 0) en = 1'b1;
      din  = rand_word();
      load = ($urandom_range(0, 14) == 0) ||
             (((pos + 1) % FRAME == 0) && $urandom_range(0, 1) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
